// File: rtl/aes192_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the AES-192
// key-schedule block.
//   NUM_RK     : round keys in an AES-192 schedule
//   NUM_WORDS  : 32-bit schedule words stored
//   NUM_EXP    : expansion steps run per key
//   RCON_INIT  : round constant loaded on key acceptance
package aes192_pkg;

   localparam int          NUM_RK    = 13;
   localparam int          NUM_WORDS = 52;
   localparam int          NUM_EXP   = 8;
   localparam logic [31:0] RCON_INIT = 32'h01000000;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      DONE
   } state_t;

   // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // AES S-box: multiplicative inverse (x^254, with 0 -> 0) then the affine
   // transform. x^254 = x^2 * x^4 * ... * x^128, built by repeated squaring.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

endpackage

// File: rtl/key_expansion_192.sv
// One AES-192 key-expansion step: six schedule words in, next six out.
//   chunk_in  : words w[6n..6n+5], first word in [191:160]
//   rcon      : round constant for this step (byte in [31:24])
//   chunk_out : words w[6n+6..6n+11], first word in [191:160]
module key_expansion_192
   import aes192_pkg::*;
(
   input  logic [191:0] chunk_in,
   input  logic [31:0]  rcon,
   output logic [191:0] chunk_out
);

   logic [31:0] c [6];
   logic [31:0] n [6];
   logic [31:0] t;

   always_comb begin
      chunk_out = '0;
      for (int j = 0; j < 6; j++) c[j] = chunk_in[191-32*j -: 32];
      // RotWord then SubWord on the last word of the previous chunk.
      t    = sub_word({c[5][23:0], c[5][31:24]}) ^ rcon;
      n[0] = c[0] ^ t;
      for (int j = 1; j < 6; j++) n[j] = c[j] ^ n[j-1];
      for (int j = 0; j < 6; j++) chunk_out[191-32*j -: 32] = n[j];
   end

endmodule

// File: rtl/aes192_key_schedule.sv
// Iterative AES-192 key schedule. A key accepted via key_valid/key_ready is
// expanded one six-word step per clock over eight clocks into w[0..51]; the
// thirteen round keys are then read combinationally in decryption order.
//   clk, rst     : clock, asynchronous active-high reset
//   key_valid    : key presented this cycle
//   key          : cipher key, w0 in [191:160]
//   key_ready    : block accepts a key (IDLE or DONE)
//   sched_valid  : all round keys stored and stable
//   rk_idx       : decryption-order index, 0 = last encryption round key
//   rk_out       : selected round key, zero for indices 13..15
module aes192_key_schedule
   import aes192_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   input  logic [191:0] key,
   output logic         key_ready,
   output logic         sched_valid,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_out
);

   state_t         state_q;
   state_t         state_d;
   logic [2:0]     cnt;
   logic [31:0]    rcon;
   logic [31:0]    w [NUM_WORDS];

   logic           accept;
   logic [5:0]     base;
   logic [191:0]   chunk;
   logic [191:0]   nxt;
   logic [NUM_WORDS-1:0] wr_en;
   logic [31:0]    wr_data [NUM_WORDS];

   key_expansion_192 u_exp (
      .chunk_in  (chunk),
      .rcon      (rcon),
      .chunk_out (nxt)
   );

   // Next-state and handshake outputs.
   always_comb begin
      state_d     = state_q;
      key_ready   = 1'b0;
      sched_valid = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            key_ready = 1'b1;
            if (key_valid) begin
               accept  = 1'b1;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            if (cnt == 3'(NUM_EXP - 1)) state_d = DONE;
         end
         DONE: begin
            key_ready   = 1'b1;
            sched_valid = 1'b1;
            if (key_valid) begin
               accept  = 1'b1;
               state_d = EXPAND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Chunk selection by step count and per-word write enables. The final
   // step would reach w[52..53]; those words have no slot and are dropped.
   always_comb begin
      base  = 6'(cnt) * 6'd6;
      chunk = '0;
      for (int j = 0; j < 6; j++) chunk[191-32*j -: 32] = w[base + 6'(j)];
      wr_en = '0;
      for (int j = 0; j < NUM_WORDS; j++) begin
         wr_data[j] = '0;
         if (state_q == EXPAND) begin
            for (int k = 0; k < 6; k++) begin
               if (int'(base) + 6 + k == j) begin
                  wr_en[j]   = 1'b1;
                  wr_data[j] = nxt[191-32*k -: 32];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt     <= 3'd0;
         rcon    <= RCON_INIT;
         for (int j = 0; j < NUM_WORDS; j++) w[j] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt  <= 3'd0;
            rcon <= RCON_INIT;
         end else if (state_q == EXPAND) begin
            cnt  <= cnt + 3'd1;
            // Eight steps only reach 0x80, so xtime never needs reduction.
            rcon <= {rcon[30:24], 25'b0};
         end
         for (int j = 0; j < 6; j++) begin
            if (accept)        w[j] <= key[191-32*j -: 32];
            else if (wr_en[j]) w[j] <= wr_data[j];
         end
         for (int j = 6; j < NUM_WORDS; j++) begin
            if (wr_en[j]) w[j] <= wr_data[j];
         end
      end
   end

   // Decryption order: index i selects encryption round key 12 - i.
   always_comb begin
      rk_out = '0;
      for (int i = 0; i < NUM_RK; i++) begin
         if (rk_idx == 4'(i)) begin
            rk_out = {w[4*(12-i)], w[4*(12-i)+1], w[4*(12-i)+2], w[4*(12-i)+3]};
         end
      end
   end

endmodule

// File: tb/tb_aes192_key_schedule.sv
// Self-checking bench for aes192_key_schedule: a reference key-schedule model
// (table S-box) feeds a scoreboard queue at each key acceptance; schedules are
// popped and compared once sched_valid rises.
module tb_aes192_key_schedule;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_valid;
   logic [191:0] key;
   logic         key_ready;
   logic         sched_valid;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [7:0]    sb [256];
   logic [1663:0] exp_q [$];

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] exp;
   } vec_t;
   vec_t fips [6];

   localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

   always #5 clk = ~clk;

   aes192_key_schedule dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key         (key),
      .key_ready   (key_ready),
      .sched_valid (sched_valid),
      .rk_idx      (rk_idx),
      .rk_out      (rk_out)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   // Reference schedule packed by decryption index: idx i at [i*128 +: 128].
   function automatic logic [1663:0] model(input logic [191:0] k);
      logic [31:0]   ew [52];
      logic [7:0]    rc;
      logic [31:0]   t;
      logic [1663:0] r;
      rc = 8'h01;
      for (int i = 0; i < 6; i++) ew[i] = k[191-32*i -: 32];
      for (int i = 6; i < 52; i++) begin
         t = ew[i-1];
         if (i % 6 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         ew[i] = ew[i-6] ^ t;
      end
      r = '0;
      for (int i = 0; i < 13; i++)
         r[i*128 +: 128] = {ew[4*(12-i)], ew[4*(12-i)+1], ew[4*(12-i)+2], ew[4*(12-i)+3]};
      return r;
   endfunction

   // Called at a negedge in IDLE/DONE; returns at the negedge after the accept edge.
   task automatic start_key(input logic [191:0] k);
      key       = k;
      key_valid = 1'b1;
      check("key_ready_before_accept", 128'(key_ready), 128'd1);
      exp_q.push_back(model(k));
      @(negedge clk);
      key_valid = 1'b0;
      check("sched_valid_after_accept", 128'(sched_valid), 128'd0);
      check("key_ready_after_accept", 128'(key_ready), 128'd0);
   endtask

   // Counts edges after acceptance until sched_valid; optionally offers a
   // foreign key while cnt is 3 and 7.
   task automatic wait_done(input bit pulse_junk);
      int m;
      m = 0;
      while (!sched_valid && m < 20) begin
         if (pulse_junk && (m == 3 || m == 7)) begin
            key_valid = 1'b1;
            key       = {6{32'hdeadbeef}} ^ 192'(m);
         end else begin
            key_valid = 1'b0;
         end
         if (key_ready) check("key_ready_in_expand", 128'(key_ready), 128'd0);
         @(negedge clk);
         m++;
      end
      key_valid = 1'b0;
      check("latency", 128'(m), 128'd8);
   endtask

   task automatic verify_sched(input string tag);
      logic [1663:0] e;
      logic [127:0]  x;
      if (exp_q.size() == 0) begin
         total_cnt++;
         $display("FAIL %s_scoreboard: got empty queue expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            #1;
            x = (i < 13) ? e[i*128 +: 128] : 128'h0;
            check($sformatf("%s_rk%0d", tag, i), rk_out, x);
         end
         check($sformatf("%s_still_valid", tag), 128'(sched_valid), 128'd1);
      end
      @(negedge clk);
   endtask

   task automatic drop_entry();
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   initial begin
      logic [2047:0] tbl;
      logic [191:0]  rk;
      tbl = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
             128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
             128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
             128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
             128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
             128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
             128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
             128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      for (int i = 0; i < 256; i++) sb[i] = tbl[2047-8*i -: 8];

      fips[0] = '{4'd12, 128'h000102030405060708090a0b0c0d0e0f};
      fips[1] = '{4'd11, 128'h10111213141516175846f2f95c43f4fe};
      fips[2] = '{4'd0,  128'ha4970a331a78dc09c418c271e3a41d5d};
      fips[3] = '{4'd13, 128'h0};
      fips[4] = '{4'd14, 128'h0};
      fips[5] = '{4'd15, 128'h0};

      // Reset state
      rst = 1'b1; key_valid = 1'b0; key = '0; rk_idx = '0;
      repeat (2) @(negedge clk);
      check("reset_key_ready", 128'(key_ready), 128'd1);
      check("reset_sched_valid", 128'(sched_valid), 128'd0);
      for (int i = 0; i < 16; i++) begin
         rk_idx = 4'(i);
         #1;
         check($sformatf("reset_rk%0d", i), rk_out, 128'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 C.2 key, known-answer table
      start_key(FIPS_KEY);
      wait_done(1'b0);
      for (int i = 0; i < 6; i++) begin
         rk_idx = fips[i].idx;
         #1;
         check($sformatf("fips_idx%0d", fips[i].idx), rk_out, fips[i].exp);
      end
      verify_sched("fips");

      // Foreign key offered during EXPAND cycles 3 and 7 is ignored
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      start_key(rk);
      wait_done(1'b1);
      verify_sched("ignore");

      // Rekey from DONE
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      start_key(rk);
      wait_done(1'b0);
      verify_sched("rekey");

      // Back-to-back accept on the first DONE cycle
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      start_key(rk);
      wait_done(1'b0);
      drop_entry();
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      start_key(rk);
      wait_done(1'b0);
      verify_sched("b2b");

      // Reset while cnt = 4
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      start_key(rk);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_key_ready", 128'(key_ready), 128'd1);
      check("midrst_sched_valid", 128'(sched_valid), 128'd0);
      for (int i = 0; i < 16; i++) begin
         rk_idx = 4'(i);
         #1;
         check($sformatf("midrst_rk%0d", i), rk_out, 128'h0);
      end
      drop_entry();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_sched_valid", 128'(sched_valid), 128'd0);
      rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      start_key(rk);
      wait_done(1'b0);
      verify_sched("postrst");

      // Random keys against the reference model
      for (int n = 0; n < 100; n++) begin
         rk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         start_key(rk);
         wait_done(1'b0);
         verify_sched($sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
